// File: rtl/zap_cp15_responder.sv
// CP15 responder: executes MCR/MRC handed over by predecode on dav/word
// and pulses done, borrowing the core register file for the transfer.
module zap_cp15_responder #(
    parameter int          CP_ID     = 15,
    parameter int          NUM_CREGS = 16,
    parameter logic [31:0] ID_VALUE  = 32'h4100_0000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_copro_dav,
    input  logic [31:0] i_copro_word,
    output logic        o_copro_done,
    output logic        o_copro_err,
    output logic        o_reg_en,
    output logic [3:0]  o_reg_rd_index,
    input  logic [31:0] i_reg_rd_data,
    output logic        o_reg_wr_en,
    output logic [3:0]  o_reg_wr_index,
    output logic [31:0] o_reg_wr_data,
    output logic [31:0] o_cr1
);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_CAP,
        WR,
        DONE,
        WAIT_LOW
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  rd_q;
    logic [3:0]  crn_q;
    logic        err_q;
    logic        is_cp;
    logic        is_mrc;
    logic        accept;
    logic        commit;
    logic [31:0] cr_val;
    logic [31:0] cr [1:NUM_CREGS-1];

    assign is_cp  = (i_copro_word[27:24] == 4'b1110) && i_copro_word[4];
    assign is_mrc = i_copro_word[20];
    assign accept = is_cp
                 && (32'(i_copro_word[11:8]) == 32'(CP_ID))
                 && (32'(i_copro_word[19:16]) < 32'(NUM_CREGS))
                 && !(is_mrc && (i_copro_word[15:12] == 4'hF));

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (i_copro_dav) begin
                    if (!accept)
                        state_nxt = DONE;
                    else if (is_mrc)
                        state_nxt = WR;
                    else
                        state_nxt = RD_REQ;
                end
            end
            RD_REQ:   state_nxt = i_copro_dav ? RD_CAP : IDLE;
            RD_CAP:   state_nxt = i_copro_dav ? DONE : IDLE;
            WR:       state_nxt = i_copro_dav ? DONE : IDLE;
            DONE:     state_nxt = i_copro_dav ? WAIT_LOW : IDLE;
            WAIT_LOW: state_nxt = i_copro_dav ? WAIT_LOW : IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= IDLE;
            rd_q  <= '0;
            crn_q <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && i_copro_dav) begin
                rd_q  <= i_copro_word[15:12];
                crn_q <= i_copro_word[19:16];
                err_q <= !accept;
            end
        end
    end

    // A dropped dav in RD_CAP is a flush, so the CR write needs dav too.
    assign commit = (state == RD_CAP) && i_copro_dav && (crn_q != 4'd0);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 1; i < NUM_CREGS; i++)
                cr[i] <= '0;
        end else if (commit) begin
            for (int i = 1; i < NUM_CREGS; i++)
                if (crn_q == i[3:0])
                    cr[i] <= i_reg_rd_data;
        end
    end

    always_comb begin
        cr_val = ID_VALUE;
        for (int i = 1; i < NUM_CREGS; i++)
            if (crn_q == i[3:0])
                cr_val = cr[i];
    end

    assign o_copro_done   = (state == DONE);
    assign o_copro_err    = (state == DONE) && err_q;
    assign o_reg_en       = (state == RD_REQ) || (state == RD_CAP)
                         || (state == WR);
    assign o_reg_rd_index = (state == RD_REQ || state == RD_CAP) ? rd_q : 4'd0;
    assign o_reg_wr_en    = (state == WR);
    assign o_reg_wr_index = (state == WR) ? rd_q : 4'd0;
    assign o_reg_wr_data  = (state == WR) ? cr_val : 32'd0;
    assign o_cr1          = cr[1];

endmodule

// File: tb/tb_zap_cp15_responder.sv
// Directed bench for zap_cp15_responder: MCR/MRC, reject, flush,
// dav hold and asynchronous reset.
module tb_zap_cp15_responder;

    logic        clk;
    logic        rst;
    logic        dav;
    logic [31:0] word;
    logic        done;
    logic        err;
    logic        reg_en;
    logic [3:0]  rd_index;
    logic [31:0] rd_data;
    logic        wr_en;
    logic [3:0]  wr_index;
    logic [31:0] wr_data;
    logic [31:0] cr1;

    int vecs = 0;
    int miss = 0;
    int pulses;

    localparam logic [31:0] ID = 32'h4100_0000;

    zap_cp15_responder dut (
        .i_clk          (clk),
        .i_reset        (rst),
        .i_copro_dav    (dav),
        .i_copro_word   (word),
        .o_copro_done   (done),
        .o_copro_err    (err),
        .o_reg_en       (reg_en),
        .o_reg_rd_index (rd_index),
        .i_reg_rd_data  (rd_data),
        .o_reg_wr_en    (wr_en),
        .o_reg_wr_index (wr_index),
        .o_reg_wr_data  (wr_data),
        .o_cr1          (cr1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_en"}, 32'(reg_en), 0);
        chk({tag, "_wren"}, 32'(wr_en), 0);
    endtask

    initial begin
        rst     = 1'b1;
        dav     = 1'b0;
        word    = '0;
        rd_data = '0;
        #3;
        chk_idle("rst0");
        chk("rst0_err", 32'(err), 0);
        chk("rst0_cr1", cr1, 0);
        chk("rst0_wrdata", wr_data, 0);
        #4 rst = 1'b0;
        step();

        // MCR p15,0,r3,c1,c0,0 <- 0x1005
        dav = 1; word = 32'hEE013F10; rd_data = 32'h0000_1005;
        step();
        chk("mcr_c1_en", 32'(reg_en), 1);
        chk("mcr_c1_idx", 32'(rd_index), 3);
        chk("mcr_c1_done", 32'(done), 0);
        step();
        chk("mcr_c2_en", 32'(reg_en), 1);
        step();
        chk("mcr_c3_done", 32'(done), 1);
        chk("mcr_c3_err", 32'(err), 0);
        chk("mcr_c3_en", 32'(reg_en), 0);
        dav = 0;
        step();
        chk("mcr_c4_cr1", cr1, 32'h0000_1005);
        chk_idle("mcr_c4");

        // MRC p15,0,r2,c0,c0,0 -> ID
        dav = 1; word = 32'hEE102F10;
        step();
        chk("mrc0_c1_wren", 32'(wr_en), 1);
        chk("mrc0_c1_en", 32'(reg_en), 1);
        chk("mrc0_c1_idx", 32'(wr_index), 2);
        chk("mrc0_c1_data", wr_data, ID);
        step();
        chk("mrc0_c2_done", 32'(done), 1);
        chk("mrc0_c2_err", 32'(err), 0);
        chk("mrc0_c2_wren", 32'(wr_en), 0);
        dav = 0;
        step();
        chk_idle("mrc0_c3");

        // MRC p15,0,r7,c1 -> CR1
        dav = 1; word = 32'hEE117F10;
        step();
        chk("mrc1_c1_idx", 32'(wr_index), 7);
        chk("mrc1_c1_data", wr_data, 32'h0000_1005);
        step();
        chk("mrc1_c2_done", 32'(done), 1);
        dav = 0;
        step();

        // Rejected: wrong coprocessor
        dav = 1; word = 32'hEE013E10;
        step();
        chk("rej14_c1_done", 32'(done), 1);
        chk("rej14_c1_err", 32'(err), 1);
        chk("rej14_c1_en", 32'(reg_en), 0);
        dav = 0;
        step();
        chk_idle("rej14_c2");
        chk("rej14_c2_err", 32'(err), 0);
        chk("rej14_cr1", cr1, 32'h0000_1005);

        // Rejected: MRC into r15
        dav = 1; word = 32'hEE10FF10;
        step();
        chk("rej15_c1_done", 32'(done), 1);
        chk("rej15_c1_err", 32'(err), 1);
        chk("rej15_c1_wren", 32'(wr_en), 0);
        dav = 0;
        step();

        // Flush an MCR in RD_CAP
        dav = 1; word = 32'hEE014F10; rd_data = 32'h0000_BEEF;
        step();
        step();
        chk("fl_c2_en", 32'(reg_en), 1);
        dav = 0;
        step();
        chk_idle("fl_c3");
        step();
        chk_idle("fl_c4");
        chk("fl_c4_cr1", cr1, 32'h0000_1005);

        // Fresh MCR after the flush
        dav = 1;
        step();
        chk("mcr2_c1_idx", 32'(rd_index), 4);
        step();
        step();
        chk("mcr2_c3_done", 32'(done), 1);
        step();
        chk("mcr2_c4_cr1", cr1, 32'h0000_BEEF);
        chk("mcr2_c4_done", 32'(done), 0);
        dav = 0;
        step();

        // Hold dav high well past done
        dav = 1; word = 32'hEE102F10;
        pulses = 0;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (done) pulses++;
            if (i == 2) chk("hold_c2_done", 32'(done), 1);
        end
        chk("hold_pulses", 32'(pulses), 1);
        chk_idle("hold_wait");
        dav = 0;
        step();
        chk_idle("hold_low");
        dav = 1; word = 32'hEE115F10;
        step();
        chk("hold2_c1_idx", 32'(wr_index), 5);
        chk("hold2_c1_data", wr_data, 32'h0000_BEEF);
        step();
        chk("hold2_c2_done", 32'(done), 1);
        dav = 0;
        step();

        // Async reset while in RD_CAP
        dav = 1; word = 32'hEE013F10; rd_data = 32'h0000_1234;
        step();
        step();
        chk("arst_pre_en", 32'(reg_en), 1);
        #2 rst = 1'b1;
        #1;
        chk_idle("arst");
        chk("arst_idx", 32'(rd_index), 0);
        chk("arst_cr1", cr1, 0);
        dav = 0;
        @(posedge clk);
        #2 rst = 1'b0;
        step();
        chk_idle("arst_after");
        chk("arst_after_cr1", cr1, 0);

        // CR1 reads back zero after reset
        dav = 1; word = 32'hEE116F10;
        step();
        chk("post_c1_wren", 32'(wr_en), 1);
        chk("post_c1_data", wr_data, 0);
        step();
        chk("post_c2_done", 32'(done), 1);
        dav = 0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule

// File: doc/zap_cp15_responder.md
Name: zap_cp15_responder

Overview:
- Coprocessor-side responder for the predecode coprocessor handshake. Predecode holds a coprocessor instruction on dav/word; this block executes it and pulses done.
- Implements MCR/MRC access to a small coprocessor register bank. Borrows the core register file through a grant-style read/write port for the transfer.
- Instantiated beside the core. Connects to o_copro_dav_ff, o_copro_word_ff and i_copro_done of the predecode stage.

Parameters:
- CP_ID, 15: coprocessor number accepted in word[11:8].
- NUM_CREGS, 16: number of 32-bit coprocessor registers. Indexed by CRn = word[19:16]; legal range 1..16.
- ID_VALUE, 32'h4100_0000: read-only contents of CR0.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_copro_dav  in  1  instruction valid, level. Word is stable while high.
- i_copro_word  in  32  coprocessor instruction.
- o_copro_done  out  1  one-cycle completion pulse.
- o_copro_err  out  1  one-cycle pulse coincident with done when the instruction is rejected.
- o_reg_en  out  1  requests core register file ownership. High in RD_REQ, RD_CAP, WR.
- o_reg_rd_index  out  4  core register to read (Rd).
- i_reg_rd_data  in  32  read data, valid the cycle after o_reg_rd_index is presented.
- o_reg_wr_en  out  1  core register write strobe.
- o_reg_wr_index  out  4  core register to write (Rd).
- o_reg_wr_data  out  32  core register write data.
- o_cr1  out  32  live copy of CR1, for control consumers.

Behaviour:
- Reset (async, i_reset=1):
  - State = IDLE.
  - All outputs 0; o_cr1=0.
  - CR1..CR(NUM_CREGS-1)=0. CR0 always reads ID_VALUE.
- All outputs are decoded from registered state/flops. There is no combinational path from any input to any output.
- Decode, sampled in IDLE:
  - MCR/MRC is word[27:24]=4'b1110 and word[4]=1. L = word[20] (1 = MRC).
  - Rd = word[15:12], CRn = word[19:16].
  - Accepted only if word[11:8]==CP_ID, CRn<NUM_CREGS, and not (MRC with Rd==15).
  - Anything else is rejected: go to DONE with the err flag set and no side effects.
- IDLE:
  - dav=1 and accepted MCR -> RD_REQ.
  - dav=1 and accepted MRC -> WR.
  - dav=1 and rejected -> DONE(err).
  - dav=0 -> stay in IDLE.
- RD_REQ: o_reg_en=1, o_reg_rd_index=Rd -> RD_CAP.
- RD_CAP:
  - o_reg_en=1. Capture i_reg_rd_data into CRn; write to CR0 is silently ignored.
  - o_cr1 updates the cycle after a CR1 write.
  - -> DONE.
- WR: o_reg_en=1, o_reg_wr_en=1, o_reg_wr_index=Rd, o_reg_wr_data=CRn (CR0 -> ID_VALUE) -> DONE.
- DONE: o_copro_done=1 for exactly one cycle; o_copro_err=1 if rejected -> WAIT_LOW.
- WAIT_LOW: stay until dav=0, then -> IDLE. One dav assertion executes exactly once.
- Latency, with dav first sampled high in cycle 0:
  - MCR: done in cycle 3.
  - MRC: done in cycle 2.
  - Rejected: done in cycle 1.
- Flush: dav=0 while in RD_REQ, RD_CAP or WR -> IDLE next cycle.
  - No done pulse.
  - No CR write and no core write in that cycle; the commit is gated by dav=1.
- dav=0 in DONE: done still pulses, then -> IDLE directly.
- A word change while dav is high is a protocol violation; behaviour is undefined and not checked.
- Reset mid-operation: immediate return to IDLE with all outputs 0. CRs are reset.

Test Plan:
- Reset with a transaction in flight (assert i_reset while in RD_CAP) -> all outputs 0 asynchronously, state IDLE, o_cr1=0.
- MCR p15,0,r3,c1,c0,0 (word=32'hEE013F10) with i_reg_rd_data=32'h0000_1005:
  - cycle 1: o_reg_en=1, o_reg_rd_index=3.
  - cycle 3: done=1, err=0.
  - cycle 4: o_cr1=32'h0000_1005.
- MRC p15,0,r2,c0,c0,0 (word=32'hEE102F10):
  - cycle 1: o_reg_wr_en=1, index=2, data=ID_VALUE.
  - cycle 2: done=1.
- Rejected MCR to p14 (word=32'hEE013E10) -> cycle 1: done=1 and err=1; no o_reg_en at any point; o_cr1 unchanged.
- MCR flushed: drop dav in RD_CAP -> no done, CR1 unchanged, IDLE next cycle. A fresh MCR afterwards completes normally.
- Hold dav high for 10 cycles after done -> done pulses exactly once, block stays in WAIT_LOW. Deassert dav, reassert it with an MRC -> a second done pulse follows.
